mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between two requesters:
  - instruction fetch (IF), read-only, word-sized;
  - the MEM-stage data access (D): read/write, byte/halfword/word, with sign-extend.
- Arbitrates between them, registers the winning request onto the memory port, and returns the response to its owner.
- Drives per-requester stall flags; the hazard unit folds these into PC_LE, nPC_LE and IF_ID_LE and into the pipeline-freeze logic.
- Data has priority (older instruction); a streak guard prevents fetch starvation.

---
 rtl/mips_mem_pkg.sv | 26 ++
 rtl/arb_starve_guard.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owners and
// the access-size encoding seen on both the D request and the memory port.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Counter width able to hold 0..max inclusive.
    function automatic int streak_width(input int max);
        return (max > 0) ? $clog2(max + 1) : 1;
    endfunction

endpackage

// File: rtl/arb_starve_guard.sv
// Data-first arbitration with a saturating streak counter so that a waiting
// fetch is granted after at most STREAK_MAX consecutive data grants.
module arb_starve_guard
    import mips_mem_pkg::*;
#(
    parameter int STREAK_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_stb,
    output logic grant_if,
    output logic grant_d
);

    localparam int SW = streak_width(STREAK_MAX);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          at_max;

    always_comb begin
        at_max   = (streak_q == SW'(STREAK_MAX));
        grant_if = if_req && (!d_req || at_max);
        grant_d  = d_req && !grant_if;

        streak_d = streak_q;
        if (grant_stb) begin
            if (grant_if) begin
                streak_d = '0;
            end else if (grant_d && if_req && !at_max) begin
                // Only count data grants that actually made a fetch wait.
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM-stage
// data access; registers the winning request and routes the response back.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW         = 9,
    parameter int DW         = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,

    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_rw,
    input  logic [1:0]    d_size,
    input  logic          d_se,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,

    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rw,
    output logic [1:0]    mem_size,
    output logic          mem_se,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,

    output logic          if_stall,
    output logic          d_stall
);

    arb_state_t    state_q,     state_d;
    arb_owner_t    owner_q,     owner_d;
    logic          mem_req_q,   mem_req_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_rw_q,    mem_rw_d;
    logic [1:0]    mem_size_q,  mem_size_d;
    logic          mem_se_q,    mem_se_d;
    logic          if_valid_q,  if_valid_d;
    logic          d_valid_q,   d_valid_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] d_rdata_q,   d_rdata_d;

    logic grant_stb;
    logic grant_if;
    logic grant_d;

    assign grant_stb = (state_q == IDLE) && (if_req || d_req);

    arb_starve_guard #(
        .STREAK_MAX (STREAK_MAX)
    ) u_starve_guard (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .d_req     (d_req),
        .grant_stb (grant_stb),
        .grant_if  (grant_if),
        .grant_d   (grant_d)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rw_d    = mem_rw_q;
        mem_size_d  = mem_size_q;
        mem_se_d    = mem_se_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_stb) begin
                    state_d   = REQ;
                    mem_req_d = 1'b1;
                    if (grant_if) begin
                        // Fetches are always plain word reads.
                        owner_d     = OWN_IF;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_rw_d    = 1'b0;
                        mem_size_d  = SZ_WORD;
                        mem_se_d    = 1'b0;
                    end else if (grant_d) begin
                        owner_d     = OWN_D;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_rw_d    = d_rw;
                        mem_size_d  = d_size;
                        mem_se_d    = d_se;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else if (owner_q == OWN_D) begin
                        d_valid_d = 1'b1;
                        if (!mem_rw_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            RESP: begin
                // Requester advances on the edge leaving RESP; no re-grant here.
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d   = IDLE;
                owner_d   = OWN_NONE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rw_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_se_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rw_q    <= mem_rw_d;
            mem_size_q  <= mem_size_d;
            mem_se_q    <= mem_se_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rw    = mem_rw_q;
    assign mem_size  = mem_size_q;
    assign mem_se    = mem_se_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    // Stalls depend only on the request and the registered valid.
    assign if_stall  = if_req && !if_valid_q;
    assign d_stall   = d_req && !d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model
// of the arbiter's grant order, latency and data return.
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_rw = 1'b0;
    logic [1:0]    d_size = 2'b00;
    logic          d_se = 1'b0;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rw;
    logic [1:0]    mem_size;
    logic          mem_se;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          if_stall;
    logic          d_stall;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STREAK_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_rw(d_rw),
        .d_size(d_size), .d_se(d_se), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
        .mem_size(mem_size), .mem_se(mem_se), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .if_stall(if_stall), .d_stall(d_stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit          resp_en = 0;
    bit          resp_rand = 0;
    bit          force_ack = 0;
    bit          rdata_fixed_en = 0;
    logic [31:0] rdata_fixed = '0;
    int          resp_wait = 0;
    int          cur_wait = 0;
    int          wait_cnt = 0;

    task automatic set_wait(input int w);
        resp_wait = w;
        cur_wait  = w;
        wait_cnt  = 0;
    endtask

    // Advance one clock, then act as the memory for the new cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
        end else if (resp_en && mem_req) begin
            if (wait_cnt >= cur_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata_fixed_en ? rdata_fixed : $urandom;
                wait_cnt  = 0;
                cur_wait  = resp_rand ? int'($urandom_range(3, 0)) : resp_wait;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        if_req    = 1'b0;
        d_req     = 1'b0;
        mem_ack   = 1'b0;
        force_ack = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        if_req = 1'b1;
        d_req  = 1'b0;
        #3;
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
        n_cmp++; if ({if_valid, d_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_valids got=%b exp=00", {if_valid, d_valid}); end
        n_cmp++; if ({mem_addr, mem_wdata, mem_size} !== '0) begin n_bad++; $display("FAIL reset_mem_attr got=%h/%h/%b exp=0", mem_addr, mem_wdata, mem_size); end
        n_cmp++; if ({if_rdata, d_rdata} !== '0) begin n_bad++; $display("FAIL reset_rdata got=%h/%h exp=0", if_rdata, d_rdata); end
        n_cmp++; if ({if_stall, d_stall} !== 2'b10) begin n_bad++; $display("FAIL reset_stalls got=%b exp=10", {if_stall, d_stall}); end
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_if_only();
        set_wait(0);
        resp_en = 1; rdata_fixed_en = 1; rdata_fixed = 32'h8C220004;
        if_addr = 9'h004; if_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            cycle();
            n_cmp++; if (mem_req !== (c == 1)) begin n_bad++; $display("FAIL if_only_mem_req c=%0d got=%0b", c, mem_req); end
            n_cmp++; if (if_valid !== (c == 2)) begin n_bad++; $display("FAIL if_only_if_valid c=%0d got=%0b", c, if_valid); end
            n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL if_only_d_valid c=%0d got=%0b exp=0", c, d_valid); end
            n_cmp++; if (if_stall !== (c == 1)) begin n_bad++; $display("FAIL if_only_stall c=%0d got=%0b", c, if_stall); end
            if (c == 1) begin
                n_cmp++;
                if ({mem_addr, mem_size, mem_rw, mem_se, mem_wdata} !== {9'h004, SZ_WORD, 1'b0, 1'b0, 32'h0}) begin
                    n_bad++; $display("FAIL if_only_attr got addr=%h size=%b rw=%b se=%b wd=%h", mem_addr, mem_size, mem_rw, mem_se, mem_wdata);
                end
            end
            if (c == 2) begin
                n_cmp++; if (if_rdata !== 32'h8C220004) begin n_bad++; $display("FAIL if_only_rdata got=%h exp=8c220004", if_rdata); end
                if_req = 1'b0;
            end
        end
    endtask

    task automatic test_d_load();
        set_wait(1);
        rdata_fixed = 32'h12345678;
        d_addr = 9'h033; d_rw = 1'b0; d_size = SZ_HALF; d_se = 1'b1; d_wdata = 32'hFFFF0000;
        d_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            cycle();
            n_cmp++; if (mem_req !== (c == 1 || c == 2)) begin n_bad++; $display("FAIL d_load_mem_req c=%0d got=%0b", c, mem_req); end
            n_cmp++; if (d_valid !== (c == 3)) begin n_bad++; $display("FAIL d_load_d_valid c=%0d got=%0b", c, d_valid); end
            n_cmp++; if (d_stall !== (c < 3)) begin n_bad++; $display("FAIL d_load_stall c=%0d got=%0b", c, d_stall); end
            if (c == 1) begin
                n_cmp++;
                if ({mem_addr, mem_size, mem_rw, mem_se, mem_wdata} !== {9'h033, SZ_HALF, 1'b0, 1'b1, 32'hFFFF0000}) begin
                    n_bad++; $display("FAIL d_load_attr got addr=%h size=%b rw=%b se=%b wd=%h", mem_addr, mem_size, mem_rw, mem_se, mem_wdata);
                end
            end
            if (c == 3) begin
                n_cmp++; if (d_rdata !== 32'h12345678) begin n_bad++; $display("FAIL d_load_rdata got=%h exp=12345678", d_rdata); end
                d_req = 1'b0;
            end
        end
    endtask

    task automatic test_d_store();
        set_wait(3);
        rdata_fixed = 32'hDEADBEEF;
        d_addr = 9'h010; d_rw = 1'b1; d_size = SZ_BYTE; d_se = 1'b0; d_wdata = 32'h000000AB;
        d_req = 1'b1;
        #1;
        n_cmp++; if (d_stall !== 1'b1) begin n_bad++; $display("FAIL d_store_stall c=0 got=%0b exp=1", d_stall); end
        for (int c = 1; c <= 6; c++) begin
            cycle();
            n_cmp++; if (mem_req !== (c >= 1 && c <= 4)) begin n_bad++; $display("FAIL d_store_mem_req c=%0d got=%0b", c, mem_req); end
            n_cmp++; if (d_valid !== (c == 5)) begin n_bad++; $display("FAIL d_store_d_valid c=%0d got=%0b", c, d_valid); end
            n_cmp++; if (d_stall !== (c < 5)) begin n_bad++; $display("FAIL d_store_stall c=%0d got=%0b", c, d_stall); end
            n_cmp++; if (d_rdata !== 32'h12345678) begin n_bad++; $display("FAIL d_store_rdata_held c=%0d got=%h exp=12345678", c, d_rdata); end
            if (c == 1) begin
                n_cmp++;
                if ({mem_addr, mem_size, mem_rw, mem_wdata} !== {9'h010, SZ_BYTE, 1'b1, 32'h000000AB}) begin
                    n_bad++; $display("FAIL d_store_attr got addr=%h size=%b rw=%b wd=%h", mem_addr, mem_size, mem_rw, mem_wdata);
                end
            end
            if (c == 5) d_req = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        bit exp_if[6];
        int ng = 0;
        int nv = 0;
        logic prev_req = 1'b0;
        exp_if = '{0, 0, 0, 0, 1, 0};
        apply_reset();
        set_wait(0); rdata_fixed_en = 0;
        if_addr = 9'h1F0;
        d_addr = 9'h020; d_rw = 1'b0; d_size = SZ_WORD; d_se = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            cycle();
            if (mem_req && !prev_req) begin
                ng++;
                n_cmp++;
                if (mem_addr !== (exp_if[ng-1] ? 9'h1F0 : 9'h020)) begin
                    n_bad++; $display("FAIL b2b_grant%0d got addr=%h exp=%h", ng, mem_addr, exp_if[ng-1] ? 9'h1F0 : 9'h020);
                end
            end
            if (if_valid || d_valid) nv++;
            if (nv < 5) begin
                n_cmp++; if (if_stall !== 1'b1) begin n_bad++; $display("FAIL b2b_if_stall c=%0d got=%0b exp=1", c, if_stall); end
            end
            if (if_valid) begin
                n_cmp++; if (nv !== 5) begin n_bad++; $display("FAIL b2b_if_valid_at got txn=%0d exp=5", nv); end
            end
            prev_req = mem_req;
        end
        n_cmp++; if (ng !== 6) begin n_bad++; $display("FAIL b2b_grant_count got=%0d exp=6", ng); end
        if_req = 1'b0; d_req = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic test_drop();
        set_wait(2);
        rdata_fixed_en = 1; rdata_fixed = 32'hCAFE0001;
        d_addr = 9'h055; d_rw = 1'b0; d_size = SZ_WORD; d_se = 1'b0;
        d_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cycle();
            n_cmp++; if (mem_req !== (c == 1 || c == 2 || c == 3 || c == 6)) begin n_bad++; $display("FAIL drop_mem_req c=%0d got=%0b", c, mem_req); end
            n_cmp++; if (d_valid !== (c == 4)) begin n_bad++; $display("FAIL drop_d_valid c=%0d got=%0b", c, d_valid); end
            n_cmp++; if (if_valid !== (c == 7)) begin n_bad++; $display("FAIL drop_if_valid c=%0d got=%0b", c, if_valid); end
            if (c == 4) begin
                n_cmp++; if (d_rdata !== 32'hCAFE0001) begin n_bad++; $display("FAIL drop_d_rdata got=%h exp=cafe0001", d_rdata); end
            end
            if (c == 6) begin
                n_cmp++; if ({mem_addr, mem_size} !== {9'h0A4, SZ_WORD}) begin n_bad++; $display("FAIL drop_if_grant got addr=%h size=%b exp=0a4/10", mem_addr, mem_size); end
            end
            if (c == 1) begin
                d_req = 1'b0; if_req = 1'b1; if_addr = 9'h0A4; resp_wait = 0;
            end
            if (c == 7) if_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int ng = 0;
        logic prev_req = 1'b0;
        apply_reset();
        set_wait(0); rdata_fixed_en = 0;
        if_addr = 9'h0C0;
        d_addr = 9'h044; d_rw = 1'b0; d_size = SZ_WORD;
        if_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            cycle();
            if (mem_req && !prev_req) begin
                ng++;
                n_cmp++; if (mem_addr !== 9'h044) begin n_bad++; $display("FAIL rmid_grant%0d got addr=%h exp=044", ng, mem_addr); end
            end
            prev_req = mem_req;
        end
        n_cmp++; if (ng !== 4) begin n_bad++; $display("FAIL rmid_grant_count got=%0d exp=4", ng); end
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rmid_in_req got=%0b exp=1", mem_req); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rmid_async_mem_req got=%0b exp=0", mem_req); end
        n_cmp++; if ({if_valid, d_valid} !== 2'b00) begin n_bad++; $display("FAIL rmid_async_valids got=%b exp=00", {if_valid, d_valid}); end
        n_cmp++; if ({mem_addr, d_rdata} !== '0) begin n_bad++; $display("FAIL rmid_async_regs got=%h/%h exp=0", mem_addr, d_rdata); end
        n_cmp++; if ({if_stall, d_stall} !== 2'b11) begin n_bad++; $display("FAIL rmid_async_stalls got=%b exp=11", {if_stall, d_stall}); end
        mem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycle();
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 9'h044}) begin n_bad++; $display("FAIL rmid_regrant got req=%0b addr=%h exp=1/044", mem_req, mem_addr); end
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_spurious_ack();
        apply_reset();
        force_ack = 1;
        for (int c = 1; c <= 4; c++) begin
            cycle();
            n_cmp++; if ({mem_req, if_valid, d_valid} !== 3'b000) begin n_bad++; $display("FAIL spur_outputs c=%0d got=%b exp=000", c, {mem_req, if_valid, d_valid}); end
            n_cmp++; if ({if_rdata, d_rdata} !== '0) begin n_bad++; $display("FAIL spur_rdata c=%0d got=%h/%h exp=0", c, if_rdata, d_rdata); end
        end
        force_ack = 0;
        set_wait(0); rdata_fixed_en = 1; rdata_fixed = 32'h00001111;
        if_addr = 9'h1FC; if_req = 1'b1;
        cycle();
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 9'h1FC}) begin n_bad++; $display("FAIL spur_next_grant got req=%0b addr=%h exp=1/1fc", mem_req, mem_addr); end
        cycle();
        n_cmp++; if ({if_valid, if_rdata} !== {1'b1, 32'h00001111}) begin n_bad++; $display("FAIL spur_next_valid got v=%0b d=%h exp=1/00001111", if_valid, if_rdata); end
        if_req = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        int          ph = 0;
        int          mown = 0;
        int          mst = 0;
        int          ngr = 0;
        logic [8:0]  e_addr = '0;
        logic [31:0] e_wdata = '0;
        logic        e_rw = 1'b0;
        logic [1:0]  e_size = '0;
        logic        e_se = 1'b0;
        logic [31:0] e_if_rd = '0;
        logic [31:0] e_d_rd = '0;
        apply_reset();
        resp_en = 1; resp_rand = 1; rdata_fixed_en = 0;
        set_wait(0);
        for (int c = 0; c < 1500; c++) begin
            cycle();
            n_cmp++; if (mem_req !== (ph == 1)) begin n_bad++; $display("FAIL rnd_mem_req c=%0d got=%0b exp=%0b", c, mem_req, ph == 1); end
            if (ph == 1) begin
                n_cmp++;
                if ({mem_addr, mem_wdata, mem_rw, mem_size, mem_se} !== {e_addr, e_wdata, e_rw, e_size, e_se}) begin
                    n_bad++; $display("FAIL rnd_attr c=%0d got=%h/%h/%b/%b/%b exp=%h/%h/%b/%b/%b", c,
                        mem_addr, mem_wdata, mem_rw, mem_size, mem_se, e_addr, e_wdata, e_rw, e_size, e_se);
                end
            end
            n_cmp++; if (if_valid !== (ph == 2 && mown == 1)) begin n_bad++; $display("FAIL rnd_if_valid c=%0d got=%0b", c, if_valid); end
            n_cmp++; if (d_valid !== (ph == 2 && mown == 2)) begin n_bad++; $display("FAIL rnd_d_valid c=%0d got=%0b", c, d_valid); end
            n_cmp++; if (if_rdata !== e_if_rd) begin n_bad++; $display("FAIL rnd_if_rdata c=%0d got=%h exp=%h", c, if_rdata, e_if_rd); end
            n_cmp++; if (d_rdata !== e_d_rd) begin n_bad++; $display("FAIL rnd_d_rdata c=%0d got=%h exp=%h", c, d_rdata, e_d_rd); end
            n_cmp++; if (if_stall !== (if_req && !(ph == 2 && mown == 1))) begin n_bad++; $display("FAIL rnd_if_stall c=%0d got=%0b", c, if_stall); end
            n_cmp++; if (d_stall !== (d_req && !(ph == 2 && mown == 2))) begin n_bad++; $display("FAIL rnd_d_stall c=%0d got=%0b", c, d_stall); end

            if (ph == 2 && mown == 1) if_req = 1'b0;
            if (ph == 2 && mown == 2) d_req = 1'b0;
            if (!if_req && $urandom_range(1, 0) == 0) begin
                if_req = 1'b1; if_addr = 9'($urandom_range(511, 0));
            end
            if (!d_req && $urandom_range(1, 0) == 0) begin
                d_req = 1'b1; d_addr = 9'($urandom_range(511, 0)); d_wdata = $urandom;
                d_rw = 1'($urandom_range(1, 0)); d_size = 2'($urandom_range(2, 0)); d_se = 1'($urandom_range(1, 0));
            end

            // Model: one transaction at a time, grant in idle, valid the cycle after ack.
            case (ph)
                0: if (if_req || d_req) begin
                    if (if_req && (!d_req || mst == SMAX)) begin
                        mown = 1; mst = 0;
                        e_addr = if_addr; e_wdata = '0; e_rw = 1'b0; e_size = 2'b10; e_se = 1'b0;
                    end else begin
                        mown = 2;
                        if (if_req && mst < SMAX) mst = mst + 1;
                        e_addr = d_addr; e_wdata = d_wdata; e_rw = d_rw; e_size = d_size; e_se = d_se;
                    end
                    ph = 1; ngr++;
                end
                1: if (mem_ack) begin
                    ph = 2;
                    if (mown == 1) e_if_rd = mem_rdata;
                    else if (!e_rw) e_d_rd = mem_rdata;
                end
                default: ph = 0;
            endcase
        end
        n_cmp++; if (ngr < 100) begin n_bad++; $display("FAIL rnd_activity got grants=%0d exp>=100", ngr); end
        if_req = 1'b0; d_req = 1'b0; resp_rand = 0;
        repeat (8) cycle();
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_d_load();
        test_d_store();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_spurious_ack();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
